conv_sequencer: RTL
===================

Name: conv_sequencer

Overview:
- Top-level controller that sequences the convolution datapath: filter load into the PE array, IFM buffer load, window fill, MAC run, accumulate and OFM write-back, one output pixel at a time.
- Sits between the system start/done handshake and the datapath control inputs.
- Drives every datapath control/address input.
- Pure control: no data-path signals pass through it.

Parameters:
N, 4, number of PEs; width of wEnFilter
FILT_WORDS, 16, memory words per PE filter
FILT_BASE, 0, memory address of PE0 filter word 0
IFM_BASE, 64, memory address of first IFM word
BUFF_WORDS, 16, main-buffer words loaded per output pixel
STRIDE, 1, IFM word advance between consecutive output pixels

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to run a layer; sampled only in IDLE
cfg_ofm_count  in  8  number of output pixels (0..255)
cfg_win  in  6  window length K (MAC cycles per pixel); 0 treated as 1
busy  out  1  high from the cycle after accepted start through the DONE cycle
done  out  1  one-cycle pulse on layer completion
w_r_EnMem  out  1  memory read enable; memory read data is combinational (same cycle)
memAddress  out  10  memory word address, modulo 1024
wEnFilter  out  N  one-hot PE filter write enable
filterCount  out  6  filter word index within PE
wEnBuff  out  1  main-buffer write enable
buffAddress  out  6  main-buffer write address
winRst  out  1  clears shift buffer and PE accumulators
writeEnwindow  out  1  shift-buffer load enable
readEnmac  out  1  MAC step enable
macCount  out  6  MAC step index
addEn  out  1  accumulate enable
wrofm  out  1  OFM write strobe (all four OFMs)
ofmaddr  out  8  OFM write address

Behaviour:
- Reset (rst=0, any time, async): state IDLE; every output 0; internal pointers 0. Mid-run reset aborts with no further wrofm; no done pulse.
- Outputs are registered (Moore); each strobe is high exactly for the listed cycles.
- IDLE: on start=1, latch cfg_ofm_count and cfg_win (K=max(cfg_win,1)); clear row_ptr and ofmaddr.
  - cfg_ofm_count=0: go to DONE.
  - Otherwise: go to LOAD_FILT.
  - start is ignored outside IDLE.
- LOAD_FILT: N*FILT_WORDS cycles, p=0..N-1 outer, f=0..FILT_WORDS-1 inner.
  - w_r_EnMem=1, memAddress=FILT_BASE+p*FILT_WORDS+f, wEnFilter=1<<p, filterCount=f.
  - Then go to LOAD_BUFF.
- LOAD_BUFF: BUFF_WORDS cycles, b=0..BUFF_WORDS-1.
  - w_r_EnMem=1, wEnBuff=1, buffAddress=b, memAddress=IFM_BASE+row_ptr+b.
- WIN_RST: 1 cycle, winRst=1.
- FILL: K cycles, writeEnwindow=1.
- MAC: K cycles, readEnmac=1, macCount=0..K-1.
- ACC: 1 cycle, addEn=1.
- WRITE: 1 cycle, wrofm=1, ofmaddr holds current pixel index.
- NEXT: 1 cycle.
  - If ofmaddr==cfg_ofm_count-1: go to DONE.
  - Else: ofmaddr+=1, row_ptr+=STRIDE, go to LOAD_BUFF. Filters are not reloaded.
- DONE: 1 cycle, done=1, busy=1; next state IDLE, busy=0.
- Per-pixel cycle count = BUFF_WORDS+2K+4. Layer total = 1 (IDLE accept) + N*FILT_WORDS + cfg_ofm_count*(BUFF_WORDS+2K+4) + 1 (DONE).
- Address arithmetic truncates to 10 bits (wrap at 1024); row_ptr is 10 bits.
- wEnFilter is all-zero outside LOAD_FILT. Never more than one of wEnBuff/wEnFilter/writeEnwindow/readEnmac/addEn/wrofm is high in a cycle.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, busy=0, done=0.
- start, cfg_ofm_count=2, cfg_win=9, defaults:
  - LOAD_FILT: 64 cycles, memAddress 0..63, wEnFilter 0001→1000 in steps of 16.
  - Pixel 0: buffer memAddress 64..79. Pixel 1: buffer memAddress 65..80.
  - Two wrofm pulses, at ofmaddr 0 and 1.
  - done exactly 1+64+2*38+1 = 142 cycles after start sampled.
- cfg_ofm_count=0 -> busy for 1 cycle then done pulse; no memory/PE/OFM strobes.
- cfg_win=0, cfg_ofm_count=1 -> FILL and MAC each last 1 cycle (macCount=0), one wrofm.
- start pulsed repeatedly during run -> ignored; exactly one done; cfg changes mid-run have no effect.
- rst low during MAC of pixel 1 -> all outputs 0 asynchronously, no wrofm or done; a fresh start afterwards runs a full layer normally.

Source files
------------

// File: rtl/conv_sequencer.sv
// Convolution layer sequencer: loads PE filters once, then walks every output
// pixel through buffer load, window fill, MAC run, accumulate and OFM write.
module conv_sequencer #(
    parameter int N          = 4,
    parameter int FILT_WORDS = 16,
    parameter int FILT_BASE  = 0,
    parameter int IFM_BASE   = 64,
    parameter int BUFF_WORDS = 16,
    parameter int STRIDE     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   cfg_ofm_count,
    input  logic [5:0]   cfg_win,
    output logic         busy,
    output logic         done,
    output logic         w_r_EnMem,
    output logic [9:0]   memAddress,
    output logic [N-1:0] wEnFilter,
    output logic [5:0]   filterCount,
    output logic         wEnBuff,
    output logic [5:0]   buffAddress,
    output logic         winRst,
    output logic         writeEnwindow,
    output logic         readEnmac,
    output logic [5:0]   macCount,
    output logic         addEn,
    output logic         wrofm,
    output logic [7:0]   ofmaddr
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_FILT,
        S_LOAD_BUFF,
        S_WIN_RST,
        S_FILL,
        S_MAC,
        S_ACC,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pe_q, pe_d;
    logic [5:0]    word_q, word_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [9:0]    row_ptr_q, row_ptr_d;
    logic [7:0]    ofm_count_q, ofm_count_d;
    logic [5:0]    win_q, win_d;
    logic [7:0]    ofmaddr_q, ofmaddr_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mem_en_q, mem_en_d;
    logic [9:0]    mem_addr_q, mem_addr_d;
    logic [N-1:0]  wen_filter_q, wen_filter_d;
    logic [5:0]    filter_count_q, filter_count_d;
    logic          wen_buff_q, wen_buff_d;
    logic [5:0]    buff_addr_q, buff_addr_d;
    logic          win_rst_q, win_rst_d;
    logic          wen_window_q, wen_window_d;
    logic          mac_en_q, mac_en_d;
    logic [5:0]    mac_count_q, mac_count_d;
    logic          add_en_q, add_en_d;
    logic          wr_ofm_q, wr_ofm_d;

    // Next-state and pointer update.
    always_comb begin
        state_d     = state_q;
        pe_d        = pe_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        row_ptr_d   = row_ptr_q;
        ofm_count_d = ofm_count_q;
        win_d       = win_q;
        ofmaddr_d   = ofmaddr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ofm_count_d = cfg_ofm_count;
                    win_d       = (cfg_win == 6'd0) ? 6'd1 : cfg_win;
                    row_ptr_d   = 10'd0;
                    ofmaddr_d   = 8'd0;
                    pe_d        = '0;
                    word_d      = 6'd0;
                    cnt_d       = 6'd0;
                    state_d     = (cfg_ofm_count == 8'd0) ? S_DONE : S_LOAD_FILT;
                end
            end
            S_LOAD_FILT: begin
                if (word_q == 6'(FILT_WORDS - 1)) begin
                    word_d = 6'd0;
                    if (pe_q == PW'(N - 1)) begin
                        cnt_d   = 6'd0;
                        state_d = S_LOAD_BUFF;
                    end else begin
                        pe_d = pe_q + PW'(1);
                    end
                end else begin
                    word_d = word_q + 6'd1;
                end
            end
            S_LOAD_BUFF: begin
                if (cnt_q == 6'(BUFF_WORDS - 1)) begin
                    cnt_d   = 6'd0;
                    state_d = S_WIN_RST;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_WIN_RST: begin
                cnt_d   = 6'd0;
                state_d = S_FILL;
            end
            S_FILL: begin
                if (cnt_q == win_q - 6'd1) begin
                    cnt_d   = 6'd0;
                    state_d = S_MAC;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_MAC: begin
                if (cnt_q == win_q - 6'd1) begin
                    cnt_d   = 6'd0;
                    state_d = S_ACC;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_ACC:   state_d = S_WRITE;
            S_WRITE: state_d = S_NEXT;
            S_NEXT: begin
                if (ofmaddr_q == ofm_count_q - 8'd1) begin
                    state_d = S_DONE;
                end else begin
                    ofmaddr_d = ofmaddr_q + 8'd1;
                    row_ptr_d = 10'(row_ptr_q + STRIDE);
                    cnt_d     = 6'd0;
                    state_d   = S_LOAD_BUFF;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
        mem_en_d       = 1'b0;
        mem_addr_d     = 10'd0;
        filter_count_d = 6'd0;
        wen_buff_d     = 1'b0;
        buff_addr_d    = 6'd0;
        win_rst_d      = (state_d == S_WIN_RST);
        wen_window_d   = (state_d == S_FILL);
        mac_en_d       = (state_d == S_MAC);
        mac_count_d    = (state_d == S_MAC) ? cnt_d : 6'd0;
        add_en_d       = (state_d == S_ACC);
        wr_ofm_d       = (state_d == S_WRITE);
        if (state_d == S_LOAD_FILT) begin
            mem_en_d       = 1'b1;
            mem_addr_d     = 10'(FILT_BASE + int'(pe_d) * FILT_WORDS + int'(word_d));
            filter_count_d = word_d;
        end else if (state_d == S_LOAD_BUFF) begin
            mem_en_d    = 1'b1;
            mem_addr_d  = 10'(IFM_BASE) + row_ptr_d + 10'(cnt_d);
            wen_buff_d  = 1'b1;
            buff_addr_d = cnt_d;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_wen_filter
        assign wen_filter_d[gi] = (state_d == S_LOAD_FILT) && (pe_d == PW'(gi));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            pe_q           <= '0;
            word_q         <= 6'd0;
            cnt_q          <= 6'd0;
            row_ptr_q      <= 10'd0;
            ofm_count_q    <= 8'd0;
            win_q          <= 6'd1;
            ofmaddr_q      <= 8'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_addr_q     <= 10'd0;
            wen_filter_q   <= '0;
            filter_count_q <= 6'd0;
            wen_buff_q     <= 1'b0;
            buff_addr_q    <= 6'd0;
            win_rst_q      <= 1'b0;
            wen_window_q   <= 1'b0;
            mac_en_q       <= 1'b0;
            mac_count_q    <= 6'd0;
            add_en_q       <= 1'b0;
            wr_ofm_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pe_q           <= pe_d;
            word_q         <= word_d;
            cnt_q          <= cnt_d;
            row_ptr_q      <= row_ptr_d;
            ofm_count_q    <= ofm_count_d;
            win_q          <= win_d;
            ofmaddr_q      <= ofmaddr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            mem_en_q       <= mem_en_d;
            mem_addr_q     <= mem_addr_d;
            wen_filter_q   <= wen_filter_d;
            filter_count_q <= filter_count_d;
            wen_buff_q     <= wen_buff_d;
            buff_addr_q    <= buff_addr_d;
            win_rst_q      <= win_rst_d;
            wen_window_q   <= wen_window_d;
            mac_en_q       <= mac_en_d;
            mac_count_q    <= mac_count_d;
            add_en_q       <= add_en_d;
            wr_ofm_q       <= wr_ofm_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign w_r_EnMem     = mem_en_q;
    assign memAddress    = mem_addr_q;
    assign wEnFilter     = wen_filter_q;
    assign filterCount   = filter_count_q;
    assign wEnBuff       = wen_buff_q;
    assign buffAddress   = buff_addr_q;
    assign winRst        = win_rst_q;
    assign writeEnwindow = wen_window_q;
    assign readEnmac     = mac_en_q;
    assign macCount      = mac_count_q;
    assign addEn         = add_en_q;
    assign wrofm         = wr_ofm_q;
    assign ofmaddr       = ofmaddr_q;

endmodule
